// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared widths, defaults and internal opcodes for the reservation station
package reservation_station_pkg;

  localparam int RS_SIZE_DEFAULT   = 8;
  localparam int ROB_WIDTH_DEFAULT = 4;
  localparam int XLEN              = 32;
  localparam int OPC_W             = 6;

  // Internal opcodes produced by the decoder for ALU, branch and JALR operations.
  typedef enum logic [OPC_W-1:0] {
    OP_ADD   = 6'd0,
    OP_SUB   = 6'd1,
    OP_SLL   = 6'd2,
    OP_SLT   = 6'd3,
    OP_SLTU  = 6'd4,
    OP_XOR   = 6'd5,
    OP_SRL   = 6'd6,
    OP_SRA   = 6'd7,
    OP_OR    = 6'd8,
    OP_AND   = 6'd9,
    OP_ADDI  = 6'd10,
    OP_SLTI  = 6'd11,
    OP_SLTIU = 6'd12,
    OP_XORI  = 6'd13,
    OP_ORI   = 6'd14,
    OP_ANDI  = 6'd15,
    OP_SLLI  = 6'd16,
    OP_SRLI  = 6'd17,
    OP_SRAI  = 6'd18,
    OP_BEQ   = 6'd19,
    OP_BNE   = 6'd20,
    OP_BLT   = 6'd21,
    OP_BGE   = 6'd22,
    OP_BLTU  = 6'd23,
    OP_BGEU  = 6'd24,
    OP_JALR  = 6'd25
  } opcode_e;

endpackage

// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - dispatch, issue and result-bus signals of the reservation station
interface reservation_station_if #(
  parameter int ROB_WIDTH = 4
);
  import reservation_station_pkg::*;

  logic                 dsp_valid;
  logic [OPC_W-1:0]     dsp_opcode;
  logic [XLEN-1:0]      dsp_vj;
  logic [XLEN-1:0]      dsp_vk;
  logic                 dsp_qj_busy;
  logic                 dsp_qk_busy;
  logic [ROB_WIDTH-1:0] dsp_qj;
  logic [ROB_WIDTH-1:0] dsp_qk;
  logic [XLEN-1:0]      dsp_imm;
  logic [XLEN-1:0]      dsp_pc;
  logic [ROB_WIDTH-1:0] dsp_rob;

  logic                 RS_full;
  logic                 RS_sgn;
  logic [OPC_W-1:0]     RS_opcode;
  logic [XLEN-1:0]      RS_lhs;
  logic [XLEN-1:0]      RS_rhs;
  logic [XLEN-1:0]      RS_imm;
  logic [XLEN-1:0]      RS_pc;
  logic [ROB_WIDTH-1:0] RS_ROB_entry;

  logic                 CDB_sgn;
  logic [ROB_WIDTH-1:0] CDB_ROB_name;
  logic [XLEN-1:0]      CDB_result;
  logic                 LCDB_sgn;
  logic [ROB_WIDTH-1:0] LCDB_ROB_name;
  logic [XLEN-1:0]      LCDB_result;

  modport master (
    output dsp_valid, dsp_opcode, dsp_vj, dsp_vk, dsp_qj_busy, dsp_qk_busy,
    output dsp_qj, dsp_qk, dsp_imm, dsp_pc, dsp_rob,
    output CDB_sgn, CDB_ROB_name, CDB_result, LCDB_sgn, LCDB_ROB_name, LCDB_result,
    input  RS_full, RS_sgn, RS_opcode, RS_lhs, RS_rhs, RS_imm, RS_pc, RS_ROB_entry
  );

  modport slave (
    input  dsp_valid, dsp_opcode, dsp_vj, dsp_vk, dsp_qj_busy, dsp_qk_busy,
    input  dsp_qj, dsp_qk, dsp_imm, dsp_pc, dsp_rob,
    input  CDB_sgn, CDB_ROB_name, CDB_result, LCDB_sgn, LCDB_ROB_name, LCDB_result,
    output RS_full, RS_sgn, RS_opcode, RS_lhs, RS_rhs, RS_imm, RS_pc, RS_ROB_entry
  );

endinterface

// File: rtl/reservation_station_select.sv
// rtl/reservation_station_select.sv - lowest-index priority encoder used for free-slot and ready-entry search
module rs_select #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo reservation station: operand capture from two result buses, lowest-index issue
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE   = RS_SIZE_DEFAULT,
  parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  reservation_station_if.slave  bus
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]                busy_q, busy_d;
  logic [RS_SIZE-1:0]                qj_busy_q, qj_busy_d;
  logic [RS_SIZE-1:0]                qk_busy_q, qk_busy_d;
  logic [RS_SIZE-1:0][OPC_W-1:0]     opcode_q, opcode_d;
  logic [RS_SIZE-1:0][XLEN-1:0]      vj_q, vj_d;
  logic [RS_SIZE-1:0][XLEN-1:0]      vk_q, vk_d;
  logic [RS_SIZE-1:0][XLEN-1:0]      imm_q, imm_d;
  logic [RS_SIZE-1:0][XLEN-1:0]      pc_q, pc_d;
  logic [RS_SIZE-1:0][ROB_WIDTH-1:0] qj_q, qj_d;
  logic [RS_SIZE-1:0][ROB_WIDTH-1:0] qk_q, qk_d;
  logic [RS_SIZE-1:0][ROB_WIDTH-1:0] rob_q, rob_d;

  logic                 rs_sgn_q, rs_sgn_d;
  logic [OPC_W-1:0]     rs_opcode_q, rs_opcode_d;
  logic [XLEN-1:0]      rs_lhs_q, rs_lhs_d;
  logic [XLEN-1:0]      rs_rhs_q, rs_rhs_d;
  logic [XLEN-1:0]      rs_imm_q, rs_imm_d;
  logic [XLEN-1:0]      rs_pc_q, rs_pc_d;
  logic [ROB_WIDTH-1:0] rs_rob_q, rs_rob_d;

  logic [RS_SIZE-1:0] free_req, ready_req;
  logic               free_found, ready_found;
  logic [IDX_W-1:0]   free_idx, ready_idx;

  logic            dsp_qj_busy_fwd, dsp_qk_busy_fwd;
  logic [XLEN-1:0] dsp_vj_fwd, dsp_vk_fwd;

  // Readiness looks only at registered flags, so a wakeup never issues in its own cycle.
  assign free_req  = ~busy_q;
  assign ready_req = busy_q & ~qj_busy_q & ~qk_busy_q;

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
    .req   (free_req),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_sel (
    .req   (ready_req),
    .found (ready_found),
    .idx   (ready_idx)
  );

  // Incoming operands may be produced by a broadcast in this very cycle; ALU bus takes priority.
  always_comb begin
    dsp_vj_fwd      = bus.dsp_vj;
    dsp_qj_busy_fwd = bus.dsp_qj_busy;
    dsp_vk_fwd      = bus.dsp_vk;
    dsp_qk_busy_fwd = bus.dsp_qk_busy;
    if (bus.dsp_qj_busy) begin
      if (bus.CDB_sgn && (bus.CDB_ROB_name == bus.dsp_qj)) begin
        dsp_vj_fwd      = bus.CDB_result;
        dsp_qj_busy_fwd = 1'b0;
      end else if (bus.LCDB_sgn && (bus.LCDB_ROB_name == bus.dsp_qj)) begin
        dsp_vj_fwd      = bus.LCDB_result;
        dsp_qj_busy_fwd = 1'b0;
      end
    end
    if (bus.dsp_qk_busy) begin
      if (bus.CDB_sgn && (bus.CDB_ROB_name == bus.dsp_qk)) begin
        dsp_vk_fwd      = bus.CDB_result;
        dsp_qk_busy_fwd = 1'b0;
      end else if (bus.LCDB_sgn && (bus.LCDB_ROB_name == bus.dsp_qk)) begin
        dsp_vk_fwd      = bus.LCDB_result;
        dsp_qk_busy_fwd = 1'b0;
      end
    end
  end

  always_comb begin
    busy_d      = busy_q;
    qj_busy_d   = qj_busy_q;
    qk_busy_d   = qk_busy_q;
    opcode_d    = opcode_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    rob_d       = rob_q;
    rs_sgn_d    = 1'b0;
    rs_opcode_d = rs_opcode_q;
    rs_lhs_d    = rs_lhs_q;
    rs_rhs_d    = rs_rhs_q;
    rs_imm_d    = rs_imm_q;
    rs_pc_d     = rs_pc_q;
    rs_rob_d    = rs_rob_q;

    if (rdy) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && qj_busy_q[i]) begin
            if (bus.CDB_sgn && (bus.CDB_ROB_name == qj_q[i])) begin
              vj_d[i]      = bus.CDB_result;
              qj_busy_d[i] = 1'b0;
            end else if (bus.LCDB_sgn && (bus.LCDB_ROB_name == qj_q[i])) begin
              vj_d[i]      = bus.LCDB_result;
              qj_busy_d[i] = 1'b0;
            end
          end
          if (busy_q[i] && qk_busy_q[i]) begin
            if (bus.CDB_sgn && (bus.CDB_ROB_name == qk_q[i])) begin
              vk_d[i]      = bus.CDB_result;
              qk_busy_d[i] = 1'b0;
            end else if (bus.LCDB_sgn && (bus.LCDB_ROB_name == qk_q[i])) begin
              vk_d[i]      = bus.LCDB_result;
              qk_busy_d[i] = 1'b0;
            end
          end
        end

        if (ready_found) begin
          rs_sgn_d          = 1'b1;
          rs_opcode_d       = opcode_q[ready_idx];
          rs_lhs_d          = vj_q[ready_idx];
          rs_rhs_d          = vk_q[ready_idx];
          rs_imm_d          = imm_q[ready_idx];
          rs_pc_d           = pc_q[ready_idx];
          rs_rob_d          = rob_q[ready_idx];
          busy_d[ready_idx] = 1'b0;
        end

        // The free slot is never the issuing slot, since that one is still busy this cycle.
        if (bus.dsp_valid && free_found) begin
          busy_d[free_idx]    = 1'b1;
          opcode_d[free_idx]  = bus.dsp_opcode;
          vj_d[free_idx]      = dsp_vj_fwd;
          vk_d[free_idx]      = dsp_vk_fwd;
          qj_busy_d[free_idx] = dsp_qj_busy_fwd;
          qk_busy_d[free_idx] = dsp_qk_busy_fwd;
          qj_d[free_idx]      = bus.dsp_qj;
          qk_d[free_idx]      = bus.dsp_qk;
          imm_d[free_idx]     = bus.dsp_imm;
          pc_d[free_idx]      = bus.dsp_pc;
          rob_d[free_idx]     = bus.dsp_rob;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      qj_busy_q   <= '0;
      qk_busy_q   <= '0;
      opcode_q    <= '0;
      vj_q        <= '0;
      vk_q        <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      qj_q        <= '0;
      qk_q        <= '0;
      rob_q       <= '0;
      rs_sgn_q    <= 1'b0;
      rs_opcode_q <= '0;
      rs_lhs_q    <= '0;
      rs_rhs_q    <= '0;
      rs_imm_q    <= '0;
      rs_pc_q     <= '0;
      rs_rob_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      qj_busy_q   <= qj_busy_d;
      qk_busy_q   <= qk_busy_d;
      opcode_q    <= opcode_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      rob_q       <= rob_d;
      rs_sgn_q    <= rs_sgn_d;
      rs_opcode_q <= rs_opcode_d;
      rs_lhs_q    <= rs_lhs_d;
      rs_rhs_q    <= rs_rhs_d;
      rs_imm_q    <= rs_imm_d;
      rs_pc_q     <= rs_pc_d;
      rs_rob_q    <= rs_rob_d;
    end
  end

  assign bus.RS_full      = ~free_found;
  assign bus.RS_sgn       = rs_sgn_q;
  assign bus.RS_opcode    = rs_opcode_q;
  assign bus.RS_lhs       = rs_lhs_q;
  assign bus.RS_rhs       = rs_rhs_q;
  assign bus.RS_imm       = rs_imm_q;
  assign bus.RS_pc        = rs_pc_q;
  assign bus.RS_ROB_entry = rs_rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed self-checking bench for reservation_station
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  reservation_station_if #(.ROB_WIDTH(4)) bus ();

  reservation_station #(.RS_SIZE(8), .ROB_WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk,
                          input logic [3:0] rob);
    bus.dsp_valid   = 1'b1;
    bus.dsp_opcode  = op;
    bus.dsp_vj      = vj;
    bus.dsp_vk      = vk;
    bus.dsp_qj_busy = qjb;
    bus.dsp_qj      = qj;
    bus.dsp_qk_busy = qkb;
    bus.dsp_qk      = qk;
    bus.dsp_rob     = rob;
    bus.dsp_imm     = 32'h100 + 32'(rob);
    bus.dsp_pc      = 32'h1000 + 32'(rob) * 4;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.RS_sgn !== 1'b0) begin failures++; $display("FAIL reset_sgn: got %0h want 0", bus.RS_sgn); end
    checks++; if (bus.RS_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %0h want 0", bus.RS_full); end
    checks++; if (bus.RS_lhs !== 32'h0 || bus.RS_rhs !== 32'h0) begin failures++; $display("FAIL reset_data: got lhs=%0h rhs=%0h want 0", bus.RS_lhs, bus.RS_rhs); end
    checks++; if (bus.RS_ROB_entry !== 4'h0 || bus.RS_opcode !== 6'h0) begin failures++; $display("FAIL reset_tag: got rob=%0h op=%0h want 0", bus.RS_ROB_entry, bus.RS_opcode); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ready_issue();
    dispatch(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    step();
    bus.dsp_valid = 1'b0;
    checks++; if (bus.RS_sgn !== 1'b0) begin failures++; $display("FAIL add_early: got sgn=%0h want 0", bus.RS_sgn); end
    step();
    checks++; if (bus.RS_sgn !== 1'b1) begin failures++; $display("FAIL add_sgn: got %0h want 1", bus.RS_sgn); end
    checks++; if (bus.RS_lhs !== 32'd5 || bus.RS_rhs !== 32'd7) begin failures++; $display("FAIL add_ops: got lhs=%0h rhs=%0h want 5 7", bus.RS_lhs, bus.RS_rhs); end
    checks++; if (bus.RS_ROB_entry !== 4'd1 || bus.RS_opcode !== 6'(OP_ADD)) begin failures++; $display("FAIL add_tag: got rob=%0h op=%0h want 1 0", bus.RS_ROB_entry, bus.RS_opcode); end
    checks++; if (bus.RS_imm !== 32'h101 || bus.RS_pc !== 32'h1004) begin failures++; $display("FAIL add_pass: got imm=%0h pc=%0h want 101 1004", bus.RS_imm, bus.RS_pc); end
    step();
    checks++; if (bus.RS_sgn !== 1'b0) begin failures++; $display("FAIL add_single: got sgn=%0h want 0", bus.RS_sgn); end
    checks++; if (bus.RS_lhs !== 32'd5) begin failures++; $display("FAIL add_hold: got lhs=%0h want 5", bus.RS_lhs); end
  endtask

  task automatic test_cdb_wakeup();
    dispatch(OP_SUB, 32'd0, 32'd4, 1'b1, 4'd3, 1'b0, 4'd0, 4'd2);
    step();
    bus.dsp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (bus.RS_sgn !== 1'b0) begin failures++; $display("FAIL sub_wait%0d: got sgn=%0h want 0", c, bus.RS_sgn); end
    end
    bus.CDB_sgn = 1'b1; bus.CDB_ROB_name = 4'd3; bus.CDB_result = 32'h20;
    step();
    bus.CDB_sgn = 1'b0;
    checks++; if (bus.RS_sgn !== 1'b0) begin failures++; $display("FAIL sub_same_cycle: got sgn=%0h want 0", bus.RS_sgn); end
    step();
    checks++; if (bus.RS_sgn !== 1'b1 || bus.RS_ROB_entry !== 4'd2) begin failures++; $display("FAIL sub_issue: got sgn=%0h rob=%0h want 1 2", bus.RS_sgn, bus.RS_ROB_entry); end
    checks++; if (bus.RS_lhs !== 32'h20 || bus.RS_rhs !== 32'd4) begin failures++; $display("FAIL sub_ops: got lhs=%0h rhs=%0h want 20 4", bus.RS_lhs, bus.RS_rhs); end
    step();
  endtask

  task automatic test_lcdb_forward();
    dispatch(OP_XOR, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd9, 4'd3);
    bus.LCDB_sgn = 1'b1; bus.LCDB_ROB_name = 4'd9; bus.LCDB_result = 32'hAB;
    step();
    bus.dsp_valid = 1'b0; bus.LCDB_sgn = 1'b0;
    step();
    checks++; if (bus.RS_sgn !== 1'b1 || bus.RS_ROB_entry !== 4'd3) begin failures++; $display("FAIL fwd_issue: got sgn=%0h rob=%0h want 1 3", bus.RS_sgn, bus.RS_ROB_entry); end
    checks++; if (bus.RS_rhs !== 32'hAB || bus.RS_lhs !== 32'd1) begin failures++; $display("FAIL fwd_ops: got lhs=%0h rhs=%0h want 1 ab", bus.RS_lhs, bus.RS_rhs); end
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.RS_full !== 1'b0) begin failures++; $display("FAIL fill_notfull%0d: got %0h want 0", i, bus.RS_full); end
      dispatch(OP_ADD, 32'd0, 32'd1, 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(i));
      step();
    end
    bus.dsp_valid = 1'b0;
    checks++; if (bus.RS_full !== 1'b1) begin failures++; $display("FAIL fill_full: got %0h want 1", bus.RS_full); end
    dispatch(OP_OR, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    step();
    bus.dsp_valid = 1'b0;
    step();
    checks++; if (bus.RS_sgn !== 1'b0) begin failures++; $display("FAIL full_drop: got sgn=%0h rob=%0h want 0", bus.RS_sgn, bus.RS_ROB_entry); end
    bus.CDB_sgn = 1'b1; bus.CDB_ROB_name = 4'd10; bus.CDB_result = 32'h55;
    step();
    bus.CDB_sgn = 1'b0;
    checks++; if (bus.RS_full !== 1'b1) begin failures++; $display("FAIL full_hold: got %0h want 1", bus.RS_full); end
    step();
    checks++; if (bus.RS_sgn !== 1'b1 || bus.RS_ROB_entry !== 4'd2 || bus.RS_lhs !== 32'h55) begin failures++; $display("FAIL full_wake: got sgn=%0h rob=%0h lhs=%0h want 1 2 55", bus.RS_sgn, bus.RS_ROB_entry, bus.RS_lhs); end
    checks++; if (bus.RS_full !== 1'b0) begin failures++; $display("FAIL full_clear: got %0h want 0", bus.RS_full); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (bus.RS_full !== 1'b0 || bus.RS_sgn !== 1'b0) begin failures++; $display("FAIL flush_pre: got full=%0h sgn=%0h want 0 0", bus.RS_full, bus.RS_sgn); end
    for (int i = 0; i < 5; i++) begin
      dispatch(OP_AND, 32'd0, 32'd2, 1'b1, 4'(i + 1), 1'b0, 4'd0, 4'(i + 1));
      step();
    end
    dispatch(OP_ADD, 32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    flush = 1'b1;
    step();
    flush = 1'b0; bus.dsp_valid = 1'b0;
    checks++; if (bus.RS_sgn !== 1'b0) begin failures++; $display("FAIL flush_sgn: got %0h want 0", bus.RS_sgn); end
    bus.CDB_sgn = 1'b1; bus.CDB_ROB_name = 4'd1; bus.CDB_result = 32'h77;
    step();
    bus.CDB_sgn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (bus.RS_sgn !== 1'b0) begin failures++; $display("FAIL flush_quiet%0d: got sgn=%0h rob=%0h want 0", c, bus.RS_sgn, bus.RS_ROB_entry); end
    end
  endtask

  task automatic test_rdy_hold();
    dispatch(OP_SLT, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
    step();
    bus.dsp_valid = 1'b0;
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (bus.RS_sgn !== 1'b0) begin failures++; $display("FAIL rdy_stall%0d: got sgn=%0h want 0", c, bus.RS_sgn); end
    end
    rdy = 1'b1;
    step();
    checks++; if (bus.RS_sgn !== 1'b1 || bus.RS_ROB_entry !== 4'd6 || bus.RS_lhs !== 32'h11) begin failures++; $display("FAIL rdy_issue: got sgn=%0h rob=%0h lhs=%0h want 1 6 11", bus.RS_sgn, bus.RS_ROB_entry, bus.RS_lhs); end
    rdy = 1'b0;
    step();
    rdy = 1'b1;
    checks++; if (bus.RS_sgn !== 1'b0) begin failures++; $display("FAIL rdy_clear: got sgn=%0h want 0", bus.RS_sgn); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) dispatch(OP_SLL, 32'(20 + k), 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'(10 + k));
      else bus.dsp_valid = 1'b0;
      step();
      if (k > 0) begin
        checks++; if (bus.RS_sgn !== 1'b1 || bus.RS_ROB_entry !== 4'(9 + k) || bus.RS_lhs !== 32'(19 + k)) begin failures++; $display("FAIL b2b_%0d: got sgn=%0h rob=%0h lhs=%0h want 1 %0h %0h", k, bus.RS_sgn, bus.RS_ROB_entry, bus.RS_lhs, 9 + k, 19 + k); end
      end
    end
    step();
    checks++; if (bus.RS_sgn !== 1'b0) begin failures++; $display("FAIL b2b_end: got sgn=%0h want 0", bus.RS_sgn); end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    bus.dsp_valid = 1'b0; bus.dsp_opcode = '0; bus.dsp_vj = '0; bus.dsp_vk = '0;
    bus.dsp_qj_busy = 1'b0; bus.dsp_qk_busy = 1'b0; bus.dsp_qj = '0; bus.dsp_qk = '0;
    bus.dsp_imm = '0; bus.dsp_pc = '0; bus.dsp_rob = '0;
    bus.CDB_sgn = 1'b0; bus.CDB_ROB_name = '0; bus.CDB_result = '0;
    bus.LCDB_sgn = 1'b0; bus.LCDB_ROB_name = '0; bus.LCDB_result = '0;
    test_reset();
    test_ready_issue();
    test_cdb_wakeup();
    test_lcdb_forward();
    test_full();
    test_flush();
    test_rdy_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Tomasulo reservation station for the out-of-order RISC-V core. Holds decoded ALU/branch/JALR operations until both source operands are known. Snoops the ALU and LSB result buses to capture pending operands. Issues one ready operation per cycle to the ALU, whose inputs are the `RS_*` signals.

## Interface
Parameters:
- `RS_SIZE`, 8: number of entries; power of two.
- `ROB_WIDTH`, 4: ROB tag width; matches `` `ROBENTRY`` and `CDB_ROB_name`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rdy` in 1: global enable. When low, only `RS_sgn` updates, and it is cleared to 0.
- `flush` in 1: branch-mispredict clear from the ROB.
- `dsp_valid` in 1: dispatch request from the decoder.
- `dsp_opcode` in 6: internal opcode (`` `ADD`` … `` `JALR``).
- `dsp_vj`, `dsp_vk` in 32: operand values. For I-type, the decoder places the immediate in `dsp_vk` with `dsp_qk_busy`=0.
- `dsp_qj_busy`, `dsp_qk_busy` in 1: operand still pending.
- `dsp_qj`, `dsp_qk` in ROB_WIDTH: producer tags of pending operands.
- `dsp_imm`, `dsp_pc` in 32: passed through unchanged.
- `dsp_rob` in ROB_WIDTH: destination ROB entry.
- `RS_full` out 1: no free entry; combinational from the current busy bits.
- `RS_sgn` out 1: issue strobe, registered.
- `RS_opcode` out 6, `RS_lhs`/`RS_rhs`/`RS_imm`/`RS_pc` out 32, `RS_ROB_entry` out ROB_WIDTH: issued operation, registered.
- `CDB_sgn` in 1, `CDB_ROB_name` in 4, `CDB_result` in 32: ALU result bus.
- `LCDB_sgn` in 1, `LCDB_ROB_name` in 4, `LCDB_result` in 32: LSB result bus.

## Operation
- **Entry fields:** `busy`, `opcode`, `vj`, `vk`, `qj`, `qk`, `qj_busy`, `qk_busy`, `imm`, `pc`, `rob`.
- **Allocation:** `dsp_valid` && !`RS_full` && !`flush` writes the lowest-index non-busy entry.
  - Dispatch while `RS_full` is ignored. The decoder must hold the instruction.
  - An entry freed by an issue in the same cycle is not reusable until the next cycle.
- **Dispatch-time forwarding:** if an incoming operand is pending and its tag equals a valid broadcast tag this cycle, store the broadcast value with busy=0.
- **Wakeup:** every busy entry compares `qj`/`qk` against both buses each cycle. On a match it loads the value and clears the busy flag.
  - The ALU bus wins if both buses carry the same tag; this is illegal by ROB uniqueness, but the behaviour is defined.
- **Select:** an entry is ready when `busy` && !`qj_busy` && !`qk_busy`, using registered state only. No same-cycle wakeup-to-issue.
- **Issue:** the lowest-index ready entry issues. Its fields are copied to `RS_*` (`vj`→`RS_lhs`, `vk`→`RS_rhs`), `RS_sgn`=1, and the entry's `busy` clears. With no ready entry, `RS_sgn`=0 and the other `RS_*` outputs hold.
- **Flush:** all `busy` bits clear and `RS_sgn` goes to 0 at the next edge. Flush overrides dispatch, wakeup and issue.
- **Reset:** all `busy`=0, `RS_sgn`=0, all `RS_*` data outputs are 0, `RS_full`=0.

## Timing
- Dispatch with ready operands at edge N → `RS_sgn`=1 during cycle N+1 → N+2.
- Operand wakeup by a broadcast in cycle c (captured at edge c) → earliest issue edge c+1.
- Throughput: one dispatch and one issue per cycle, concurrently.
- `RS_full` is combinational. The entry count seen by the decoder is exact as of the last edge.
- `rst` asserted mid-operation clears state immediately (asynchronous). There is no partial-issue recovery; the ROB is reset simultaneously.

## Structure
- `defines.v` owns the opcode macros, `` `ROBENTRY``, and the `RS_SIZE` default.
- Sub-module `rs_select`: a parameterised lowest-index priority encoder with `found` flag and index outputs.
  - One instance for the free-slot search.
  - One instance for the ready-entry search.
- All remaining logic (entry arrays, wakeup comparators, output registers) lives in the top module.

## Test plan
- **Reset, then dispatch `ADD` with vj=5, vk=7, both ready:** exactly one pulse of `RS_sgn` two edges later, with `RS_lhs`=5, `RS_rhs`=7 and the matching `RS_ROB_entry`.
- **Dispatch `SUB` with qj=3 pending, then `CDB_sgn`=1, `CDB_ROB_name`=3, `CDB_result`=0x20 three cycles later:** issue one edge after the broadcast with `RS_lhs`=0x20.
- **Dispatch with qk=9 in the same cycle as `LCDB` tag 9 carries value 0xAB:** entry is ready immediately and issues with `RS_rhs`=0xAB.
- **Fill 8 non-ready entries:** `RS_full`=1 and a ninth dispatch is dropped. Waking entry 2 issues entry 2 and clears `RS_full`.
- **`flush` with 5 busy entries plus a simultaneous dispatch:** all entries clear, nothing issues afterward, and `RS_sgn`=0.
- **Hold `rdy`=0 for 3 cycles with a ready entry:** no issue and the entry is retained. Issue occurs one edge after `rdy` returns high.
